wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter Size, default 64, the width of the write-back data in bits.
REQ-002 The block SHALL have parameter AddrSize, default 5, the width of the destination register address in bits.
REQ-003 The block SHALL have parameter ZeroReg, default 1; when 1, address 0 is hardwired and writes to it are discarded.

Ports (name, direction, width, meaning):
REQ-004 clk  input  1  Single clock; all state updates on the posedge.
REQ-005 reset  input  1  Synchronous, active-high reset.
REQ-006 stall_i  input  1  When 1, the block grants no requester this cycle.
REQ-007 valid_i  input  3  Per-requester write request; bit 0 is ALU, bit 1 is FPU, bit 2 is load unit.
REQ-008 addr_i  input  3*AddrSize  Flattened destination addresses; requester k uses slice [k*AddrSize +: AddrSize].
REQ-009 data_i  input  3*Size  Flattened write data; requester k uses slice [k*Size +: Size].
REQ-010 ready_o  output  3  Combinational one-hot grant; a transfer occurs for requester k when valid_i[k] & ready_o[k].
REQ-011 we_o  output  1  Registered write enable to the register-file write port.
REQ-012 waddr_o  output  AddrSize  Registered write address.
REQ-013 wdata_o  output  Size  Registered write data.
REQ-014 ptr_o  output  2  Current round-robin priority pointer, for debug and verification.

Function
REQ-015 At most one ready_o bit SHALL be 1 in any cycle.
REQ-016 ready_o SHALL be all 0 whenever reset=1, stall_i=1, or valid_i=0.
REQ-017 The grant SHALL go to the first set valid_i bit found searching ptr, ptr+1, ptr+2 (mod 3).
REQ-018 ready_o SHALL depend only on valid_i, stall_i, reset and ptr, never on address or data.
REQ-019 After a transfer from requester k, ptr SHALL become (k+1) mod 3 on the next posedge.
REQ-020 ptr SHALL hold its value in any cycle without a transfer.
REQ-021 ptr SHALL only take the values 0, 1 and 2.
REQ-022 Latency from transfer to write port SHALL be exactly 1 cycle.
REQ-023 On the posedge after a transfer from requester k, waddr_o and wdata_o SHALL equal that requester's address and data slices.
REQ-024 On that same posedge, we_o SHALL be 1, except that it SHALL be 0 when ZeroReg=1 and the address is 0.
REQ-025 A discarded address-0 write SHALL still complete its handshake and still advance ptr.
REQ-026 In a cycle without a transfer, we_o SHALL be 0 on the next posedge.
REQ-027 In a cycle without a transfer, waddr_o and wdata_o SHALL hold their previous values.
REQ-028 A requester SHALL keep valid, address and data stable until it is granted.
REQ-029 The arbiter SHALL NOT require that a requester drop valid after a grant; back-to-back transfers from one requester are legal.
REQ-030 When several requesters are valid, each SHALL be granted within 3 non-stalled cycles (no starvation).
REQ-031 The block SHALL perform no address-conflict detection; two grants to the same address in consecutive cycles SHALL produce two writes in grant order.

Reset
REQ-032 While reset=1 at a posedge: ptr:=0, we_o:=0, waddr_o:=0, wdata_o:=0.
REQ-033 A request presented while reset=1 SHALL NOT be granted and SHALL NOT produce a write.
REQ-034 A transfer in the cycle reset rises SHALL be lost: we_o is 0 after that posedge.
REQ-035 Normal arbitration SHALL resume in the first cycle with reset=0, starting from ptr=0.

Verification
REQ-036 Reset, then valid_i=3'b001, addr0=5, data0=64'hDEAD -> ready_o=001 in the same cycle; next posedge we_o=1, waddr_o=5, wdata_o=64'hDEAD, ptr_o=1.
REQ-037 From ptr=0, valid_i=3'b111 held for 6 cycles -> grant order 0,1,2,0,1,2; ptr_o sequence 1,2,0,1,2,0; one write per cycle.
REQ-038 ptr=1 and valid_i=3'b101 -> requester 2 granted first, then 0, then 2 again; requester 1 never granted.
REQ-039 valid_i=3'b010, addr1=0, ZeroReg=1 -> ready_o=010; next posedge we_o=0; ptr_o goes 1->2.
REQ-040 stall_i=1 for 3 cycles with valid_i=3'b111 -> ready_o=000 and we_o=0 throughout, ptr unchanged; grants resume the cycle stall_i=0.
REQ-041 1000 random cycles (random valid_i, stall_i, addresses, data) with reset pulsed every 100 cycles -> all rules hold versus a reference model; print the error count at the end.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Request and write-port signals of the three-way write-back arbiter.
// The slave modport is the arbiter side; the master modport drives requests and observes the write port.
interface wb_port_arbiter_if #(
    parameter int Size     = 64,
    parameter int AddrSize = 5
);
    logic                  stall_i;
    logic [2:0]            valid_i;
    logic [3*AddrSize-1:0] addr_i;
    logic [3*Size-1:0]     data_i;
    logic [2:0]            ready_o;
    logic                  we_o;
    logic [AddrSize-1:0]   waddr_o;
    logic [Size-1:0]       wdata_o;
    logic [1:0]            ptr_o;

    modport slave (
        input  stall_i, valid_i, addr_i, data_i,
        output ready_o, we_o, waddr_o, wdata_o, ptr_o
    );

    modport master (
        output stall_i, valid_i, addr_i, data_i,
        input  ready_o, we_o, waddr_o, wdata_o, ptr_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter that merges ALU, FPU and load-unit results onto one register-file write port.
// The grant is combinational; the selected write reaches the port one cycle later.
module wb_port_arbiter #(
    parameter int Size     = 64,
    parameter int AddrSize = 5,
    parameter int ZeroReg  = 1
) (
    input logic               clk,
    input logic               reset,
    wb_port_arbiter_if.slave  bus
);

    logic [1:0]          ptr_p1;
    logic [2:0]          grant_p0;
    logic                vld_p0;
    logic [AddrSize-1:0] addr_p0;
    logic [Size-1:0]     data_p0;
    logic [1:0]          next_ptr_p0;
    logic                we_p1;
    logic [AddrSize-1:0] waddr_p1;
    logic [Size-1:0]     wdata_p1;

    // Search order starts at the pointer and wraps; pointer value 3 never occurs.
    function automatic logic [2:0] rr_pick(input logic [2:0] v, input logic [1:0] p);
        logic [1:0] o0, o1, o2;
        logic [2:0] g;
        g = '0;
        case (p)
            2'd1:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd2:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
        endcase
        if (v[o0])      g[o0] = 1'b1;
        else if (v[o1]) g[o1] = 1'b1;
        else if (v[o2]) g[o2] = 1'b1;
        return g;
    endfunction

    function automatic logic is_write(input logic [AddrSize-1:0] a);
        return !((ZeroReg != 0) && (a == '0));
    endfunction

    // Stage p0: grant and operand select
    always_comb begin
        grant_p0 = '0;
        if (!reset && !bus.stall_i) begin
            grant_p0 = rr_pick(bus.valid_i, ptr_p1);
        end
    end

    assign vld_p0 = |grant_p0;

    always_comb begin
        addr_p0     = bus.addr_i[0 +: AddrSize];
        data_p0     = bus.data_i[0 +: Size];
        next_ptr_p0 = 2'd1;
        if (grant_p0[1]) begin
            addr_p0     = bus.addr_i[AddrSize +: AddrSize];
            data_p0     = bus.data_i[Size +: Size];
            next_ptr_p0 = 2'd2;
        end else if (grant_p0[2]) begin
            addr_p0     = bus.addr_i[2*AddrSize +: AddrSize];
            data_p0     = bus.data_i[2*Size +: Size];
            next_ptr_p0 = 2'd0;
        end
    end

    // Stage p1: registered write port and priority pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_p1   <= 2'd0;
            we_p1    <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else begin
            we_p1 <= vld_p0 && is_write(addr_p0);
            if (vld_p0) begin
                ptr_p1   <= next_ptr_p0;
                waddr_p1 <= addr_p0;
                wdata_p1 <= data_p0;
            end
        end
    end

    assign bus.ready_o = grant_p0;
    assign bus.we_o    = we_p1;
    assign bus.waddr_o = waddr_p1;
    assign bus.wdata_o = wdata_p1;
    assign bus.ptr_o   = ptr_p1;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table followed by constrained-random traffic
// compared against a round-robin reference model.
module tb_wb_port_arbiter;
    localparam int SIZE = 64;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.Size(SIZE), .AddrSize(AW)) bus ();

    wb_port_arbiter #(.Size(SIZE), .AddrSize(AW), .ZeroReg(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: pointer as a plain integer 0..2 and the expected write port.
    int          m_ptr;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [63:0] m_wdata;

    typedef struct {
        bit          rst;
        bit          stall;
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [191:0] data;
        logic [2:0]  exp_ready;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic [63:0] exp_wdata;
        logic [1:0]  exp_ptr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit st, logic [2:0] v,
                                logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                                logic [63:0] d0, logic [63:0] d1, logic [63:0] d2,
                                logic [2:0] er, logic ew, logic [4:0] ea,
                                logic [63:0] ed, logic [1:0] ep);
        vec_t x;
        x.rst = r; x.stall = st; x.valid = v;
        x.addr = {a2, a1, a0};
        x.data = {d2, d1, d0};
        x.exp_ready = er; x.exp_we = ew; x.exp_waddr = ea;
        x.exp_wdata = ed; x.exp_ptr = ep;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // First valid requester found walking ptr, ptr+1, ptr+2 modulo 3; -1 when none is granted.
    function automatic int model_grant(bit r, bit st, logic [2:0] v, int p);
        if (r || st) return -1;
        for (int i = 0; i < 3; i++) begin
            if (v[(p + i) % 3]) return (p + i) % 3;
        end
        return -1;
    endfunction

    task automatic run_cycle(input bit r, input bit st, input logic [2:0] v,
                             input logic [14:0] a, input logic [191:0] d,
                             output logic [2:0] got_ready, output int g);
        logic [2:0] exp_ready;
        reset       = r;
        bus.stall_i = st;
        bus.valid_i = v;
        bus.addr_i  = a;
        bus.data_i  = d;
        #1;
        g = model_grant(r, st, v, m_ptr);
        exp_ready = (g < 0) ? 3'b000 : (3'b001 << g);
        got_ready = bus.ready_o;
        check("ready", 64'(bus.ready_o), 64'(exp_ready));
        @(posedge clk);
        if (r) begin
            m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        end else if (g >= 0) begin
            m_waddr = a[g*AW +: AW];
            m_wdata = d[g*SIZE +: SIZE];
            m_we    = (m_waddr != 5'd0);
            m_ptr   = (g + 1) % 3;
        end else begin
            m_we = 1'b0;
        end
        #1;
        check("we",    64'(bus.we_o),    64'(m_we));
        check("waddr", 64'(bus.waddr_o), 64'(m_waddr));
        check("wdata", bus.wdata_o,      m_wdata);
        check("ptr",   64'(bus.ptr_o),   64'(m_ptr));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [2:0]   rdy;
        int           g;
        logic [2:0]   pend;
        logic [14:0]  ra;
        logic [191:0] rd;
        int           wait_cnt[3];
        bit           r, st;

        // Directed vectors; expectations are hand-derived from the arbitration rules.
        vecs.push_back(mk(1, 0, 3'b111, 0, 0, 0, 0, 0, 0,                     3'b000, 0, 0, 64'h0, 0));
        vecs.push_back(mk(0, 0, 3'b001, 5, 0, 0, 64'hDEAD, 0, 0,              3'b001, 1, 5, 64'hDEAD, 1));
        vecs.push_back(mk(0, 0, 3'b000, 5, 0, 0, 64'hDEAD, 0, 0,              3'b000, 0, 5, 64'hDEAD, 1));
        vecs.push_back(mk(0, 0, 3'b101, 3, 0, 7, 64'hA0, 0, 64'hC2,           3'b100, 1, 7, 64'hC2, 0));
        vecs.push_back(mk(0, 0, 3'b101, 3, 0, 7, 64'hA0, 0, 64'hC2,           3'b001, 1, 3, 64'hA0, 1));
        vecs.push_back(mk(0, 0, 3'b101, 3, 0, 7, 64'hA0, 0, 64'hC2,           3'b100, 1, 7, 64'hC2, 0));
        for (int k = 0; k < 2; k++) begin
            vecs.push_back(mk(0, 0, 3'b111, 1, 2, 3, 64'h10, 64'h20, 64'h30,  3'b001, 1, 1, 64'h10, 1));
            vecs.push_back(mk(0, 0, 3'b111, 1, 2, 3, 64'h10, 64'h20, 64'h30,  3'b010, 1, 2, 64'h20, 2));
            vecs.push_back(mk(0, 0, 3'b111, 1, 2, 3, 64'h10, 64'h20, 64'h30,  3'b100, 1, 3, 64'h30, 0));
        end
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(0, 1, 3'b111, 1, 2, 3, 64'h10, 64'h20, 64'h30,  3'b000, 0, 3, 64'h30, 0));
        end
        vecs.push_back(mk(0, 0, 3'b111, 1, 2, 3, 64'h10, 64'h20, 64'h30,      3'b001, 1, 1, 64'h10, 1));
        vecs.push_back(mk(0, 0, 3'b010, 0, 0, 0, 0, 64'h55, 0,                3'b010, 0, 0, 64'h55, 2));
        vecs.push_back(mk(0, 0, 3'b011, 9, 9, 0, 64'h90, 64'h91, 0,           3'b001, 1, 9, 64'h90, 1));
        vecs.push_back(mk(0, 0, 3'b011, 9, 9, 0, 64'h90, 64'h91, 0,           3'b010, 1, 9, 64'h91, 2));
        vecs.push_back(mk(1, 0, 3'b111, 9, 9, 0, 64'h90, 64'h91, 0,           3'b000, 0, 0, 64'h0, 0));
        vecs.push_back(mk(0, 0, 3'b010, 0, 4, 0, 0, 64'h44, 0,                3'b010, 1, 4, 64'h44, 2));
        vecs.push_back(mk(0, 0, 3'b010, 0, 6, 0, 0, 64'h66, 0,                3'b010, 1, 6, 64'h66, 2));

        reset = 1'b1;
        bus.stall_i = 1'b0;
        bus.valid_i = '0;
        bus.addr_i  = '0;
        bus.data_i  = '0;
        m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_cycle(vecs[i].rst, vecs[i].stall, vecs[i].valid, vecs[i].addr, vecs[i].data, rdy, g);
            check($sformatf("v%0d_ready", i), 64'(rdy),           64'(vecs[i].exp_ready));
            check($sformatf("v%0d_we", i),    64'(bus.we_o),      64'(vecs[i].exp_we));
            check($sformatf("v%0d_waddr", i), 64'(bus.waddr_o),   64'(vecs[i].exp_waddr));
            check($sformatf("v%0d_wdata", i), bus.wdata_o,        vecs[i].exp_wdata);
            check($sformatf("v%0d_ptr", i),   64'(bus.ptr_o),     64'(vecs[i].exp_ptr));
        end

        // Random traffic: a pending request keeps valid, address and data until granted.
        pend = '0; ra = '0; rd = '0;
        for (int k = 0; k < 3; k++) wait_cnt[k] = 0;
        for (int c = 0; c < 1000; c++) begin
            r  = (c % 100 == 0);
            st = ($urandom % 4 == 0);
            for (int k = 0; k < 3; k++) begin
                if (!pend[k]) begin
                    pend[k] = $urandom % 2;
                    ra[k*AW +: AW]     = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
                    rd[k*SIZE +: SIZE] = {$urandom, $urandom};
                end
            end
            run_cycle(r, st, pend, ra, rd, rdy, g);
            if (r) begin
                pend = '0;
                for (int k = 0; k < 3; k++) wait_cnt[k] = 0;
            end else begin
                if (!st) begin
                    for (int k = 0; k < 3; k++) begin
                        if (pend[k]) begin
                            wait_cnt[k] = (g == k) ? 0 : wait_cnt[k] + 1;
                            check($sformatf("starve%0d", k), 64'(wait_cnt[k] < 3), 64'd1);
                        end
                    end
                end
                if (g >= 0) pend[g] = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
